// File: rtl/nmi_pkg.sv
// Shared types for the NMI service path.
package nmi_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } nmi_state_e;

endpackage

// File: rtl/nmi_pend_counter.sv
// Saturating up/down counter holding NMIs that are queued but not yet acknowledged.
module nmi_pend_counter #(
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] count,
   output logic [PEND_W-1:0] count_next,
   output logic              sat
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   assign sat = (count == CNT_MAX);

   // inc together with dec is a net zero, so saturation never drops a request then
   always_comb begin
      count_next = count;
      case ({inc, dec})
         2'b10:   if (!sat) count_next = count + 1'b1;
         2'b01:   if (count != '0) count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else     count <= count_next;
   end

endmodule

// File: rtl/nmi_service_unit.sv
// NMI consumer: queues NMI events, runs the request/acknowledge/return handshake
// with the CPU and flags dropped NMIs and acknowledge timeouts.
//
// state   | meaning
// IDLE    | nothing pending, no handler running
// REQUEST | nmi_irq raised, waiting for cpu_ack
// SERVICE | handler running, waiting for nmi_ret
module nmi_service_unit
   import nmi_pkg::*;
#(
   parameter int                PEND_W      = 2,
   parameter int                VEC_W       = 8,
   parameter logic [VEC_W-1:0]  NMI_VECTOR  = 8'h02,
   parameter int                ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              nmi_req,
   input  logic              cpu_ack,
   input  logic              nmi_ret,
   input  logic              err_clr,
   output logic              nmi_irq,
   output logic [VEC_W-1:0]  nmi_vector,
   output logic              nmi_active,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              pend_ovf,
   output logic              ack_timeout
);

   localparam int              TMO_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   nmi_state_e        state, state_next;
   logic [PEND_W-1:0] pend_next;
   logic              pend_sat;
   logic              pend_dec;
   logic              ovf_set;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              tmo_fire;
   logic              enter_req;

   assign pend_dec = (state == REQUEST) && cpu_ack;
   assign ovf_set  = nmi_req && !pend_dec && pend_sat;

   nmi_pend_counter #(
      .PEND_W (PEND_W)
   ) u_pend (
      .clk        (clk),
      .rst        (rst),
      .inc        (nmi_req),
      .dec        (pend_dec),
      .count      (pend_cnt),
      .count_next (pend_next),
      .sat        (pend_sat)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pend_next != '0) state_next = REQUEST;
         REQUEST: if (cpu_ack) state_next = SERVICE;
         SERVICE: if (nmi_ret) state_next = (pend_next != '0) ? REQUEST : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Down-counter: loaded with ACK_TIMEOUT on entry, fires on the cycle it reads 1
   // (the ACK_TIMEOUT-th cycle in REQUEST), then parks at 0 so it fires only once.
   assign enter_req = (state_next == REQUEST) && (state != REQUEST);
   assign tmo_fire  = (state == REQUEST) && !cpu_ack && (tmo_cnt == TMO_ONE);

   always_ff @(posedge clk) begin
      if (rst)                                      tmo_cnt <= '0;
      else if (enter_req)                           tmo_cnt <= TMO_LOAD;
      else if ((state == REQUEST) && (tmo_cnt != '0)) tmo_cnt <= tmo_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_ovf    <= 1'b0;
         ack_timeout <= 1'b0;
      end else begin
         if (ovf_set)      pend_ovf <= 1'b1;
         else if (err_clr) pend_ovf <= 1'b0;
         if (tmo_fire)     ack_timeout <= 1'b1;
         else if (err_clr) ack_timeout <= 1'b0;
      end
   end

   assign nmi_irq    = (state == REQUEST);
   assign nmi_active = (state == SERVICE);
   assign nmi_vector = nmi_irq ? NMI_VECTOR : '0;

endmodule

// File: doc/nmi_service_unit.md
# nmi_service_unit

Consumer end of the NMI path. It accepts the one-cycle `nmi_req` pulses produced by the NMI input edge detector and queues them in a saturating pending counter. It presents a level request plus vector to the CPU, runs the acknowledge / in-service / return handshake, and flags overflow and acknowledge timeout. It sits between the NMI input unit and the CPU interrupt port.

## Interface
Parameters:
- `PEND_W`, default 2: pending counter width; maximum queued NMIs = 2^PEND_W−1.
- `VEC_W`, default 8: vector width.
- `NMI_VECTOR`, default 8'h02: vector value presented while requesting.
- `ACK_TIMEOUT`, default 16: cycles in REQUEST without `cpu_ack` before `ack_timeout` sets; must be ≥2.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `nmi_req` in 1: one-cycle NMI event pulse.
- `cpu_ack` in 1: CPU accepts the request; one-cycle pulse.
- `nmi_ret` in 1: CPU finished the NMI handler; one-cycle pulse.
- `err_clr` in 1: clears the sticky error flags.
- `nmi_irq` out 1: request level to the CPU.
- `nmi_vector` out VEC_W: `NMI_VECTOR` while `nmi_irq` = 1, else 0.
- `nmi_active` out 1: handler in service.
- `pend_cnt` out PEND_W: queued NMIs not yet acknowledged.
- `pend_ovf` out 1: sticky; an NMI was dropped at saturation.
- `ack_timeout` out 1: sticky; acknowledge timeout occurred.

## Operation
- Three states: IDLE, REQUEST, SERVICE. Outputs decode from the registered state: `nmi_irq` = REQUEST, `nmi_active` = SERVICE.
- Pending counter update each cycle:
  - inc = `nmi_req`; dec = (state == REQUEST & `cpu_ack`).
  - next = pend_cnt + inc − dec.
  - Saturates at 2^PEND_W−1. An inc at saturation with no dec leaves the count unchanged and sets `pend_ovf`.
  - Never underflows: dec only occurs in REQUEST, where the count is ≥1.
- Transitions, evaluated on the next count value:
  - IDLE → REQUEST when next ≠ 0.
  - REQUEST → SERVICE on `cpu_ack`.
  - SERVICE → REQUEST on `nmi_ret` if next ≠ 0; SERVICE → IDLE on `nmi_ret` if next = 0.
- Ignored inputs:
  - `cpu_ack` outside REQUEST is ignored.
  - `nmi_ret` outside SERVICE is ignored.
  - `nmi_req` is always counted, in every state.
- Timeout counter:
  - Clears on every entry to REQUEST and counts each cycle spent in REQUEST.
  - At `ACK_TIMEOUT`−1 with no `cpu_ack`, sets `ack_timeout`. The counter then holds, and the state stays REQUEST with `nmi_irq` held.
- `err_clr` clears both sticky flags. If a set condition occurs in the same cycle, set wins.

## Timing
- Reset values: state IDLE, `pend_cnt` 0, `nmi_irq` 0, `nmi_vector` 0, `nmi_active` 0, `pend_ovf` 0, `ack_timeout` 0, timeout counter 0.
- Reset mid-operation drops all pending NMIs and aborts service. The next cycle is IDLE.
- Latencies:
  - `nmi_req` in cycle N → `nmi_irq` = 1 and `pend_cnt` incremented in cycle N+1 (from IDLE).
  - `cpu_ack` in cycle N → `nmi_irq` = 0, `nmi_active` = 1, `pend_cnt` decremented in cycle N+1.
  - `nmi_ret` in cycle N → `nmi_active` = 0 in N+1, with `nmi_irq` = 1 in N+1 if anything is pending.
- Simultaneous events:
  - `nmi_req` + `cpu_ack` in the same cycle: count unchanged, state → SERVICE.
  - `nmi_req` + `nmi_ret` in the same cycle with count 0: → REQUEST with count 1.
  - `nmi_req` at saturation + `cpu_ack` in the same cycle: no overflow, count unchanged.

## Structure
- Package `nmi_pkg`: state enum `nmi_state_e` {IDLE, REQUEST, SERVICE}.
- Sub-module `nmi_pend_counter`: PEND_W-bit saturating up/down counter with inc, dec and sat outputs. It is instantiated once.
- FSM, timeout counter and sticky flags stay in the top module.

## Test plan
- Reset, then one `nmi_req`, `cpu_ack` 3 cycles later, `nmi_ret` 5 cycles after that:
  - `nmi_irq` high in cycles 1–3; `nmi_vector` = 8'h02 in those cycles.
  - `nmi_active` high in cycles 4–8, then IDLE; `pend_cnt` 1→0.
- Three `nmi_req` pulses while in SERVICE (count 0): `pend_cnt` = 3, no overflow. A fourth sets `pend_ovf` with count staying 3. Each subsequent `nmi_ret`/`cpu_ack` pair decrements the count by one, reaching IDLE after the third.
- `nmi_req` and `cpu_ack` in the same cycle in REQUEST with count 1: count stays 1 → SERVICE. On `nmi_ret`, `nmi_irq` rises the next cycle.
- No `cpu_ack` for 16 cycles in REQUEST: `ack_timeout` sets after the 16th cycle and `nmi_irq` stays high. `err_clr` clears the flag. A late `cpu_ack` still enters SERVICE.
- Spurious `cpu_ack` in IDLE and spurious `nmi_ret` in REQUEST: no state change and no count change.
- `rst` asserted during SERVICE with count 2: all outputs at reset values in the next cycle, and no request follows.
